mp3_byte_fifo: RTL and testbench

- Buffers 16-bit MP3 bitstream words written by the host bus interface.
- Passes each word once through the descrambler and splits the result into bytes for the 8-bit serial data feeder.
- Sits between the host register file and the descrambler/feeder pair.
- Owns the descrambler key-advance strobe, so keys step exactly once per word consumed.

---
 rtl/mp3_byte_fifo.sv | 81 ++++++++
 tb/tb_mp3_byte_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mp3_byte_fifo.sv
// mp3_byte_fifo: word FIFO feeding a descrambler and splitting each word into two bytes for the feeder.
module mp3_byte_fifo #(
  parameter int DEPTH = 16,
  parameter bit LITTLE_ENDIAN = 1'b0,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [15:0]   wrData,
  input  logic          wrEn,
  output logic          full,
  output logic [CW-1:0] wordCount,
  output logic          overflow,
  output logic          underrun,
  input  logic          clearFlags,
  output logic [15:0]   descramblerIn,
  input  logic [15:0]   descramblerOut,
  output logic          descramblerAck,
  output logic [7:0]    byteOut,
  output logic          byteReady,
  input  logic          byteAck,
  input  logic          consumerReq
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, BYTE0, BYTE1} state_t;
  state_t state, state_n;
  logic [15:0] mem [DEPTH];
  logic [15:0] rd_q, hold;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign full = count == CW'(DEPTH);
  assign wordCount = count;
  assign push = wrEn && !full && !flush;
  assign pop = !flush && count != '0 && (state == IDLE || (state == BYTE1 && byteAck));
  assign byteReady = state == BYTE0 || state == BYTE1;
  // A flush landing in LATCH must not step the keys, so the strobe stays combinational.
  assign descramblerAck = state == LATCH && !flush;
  assign byteOut = state == BYTE0 ? (LITTLE_ENDIAN ? hold[7:0] : hold[15:8]) :
                   state == BYTE1 ? (LITTLE_ENDIAN ? hold[15:8] : hold[7:0]) : 8'h00;
  always_comb begin
    state_n = pop ? FETCH :
              state == FETCH ? LATCH :
              state == LATCH ? BYTE0 :
              state == BYTE0 && byteAck ? BYTE1 :
              state == BYTE1 && byteAck ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wrData;
    if (pop) rd_q <= mem[rptr];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      descramblerIn <= '0;
      hold <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      overflow <= (wrEn && full) || (overflow && !clearFlags);
      underrun <= (consumerReq && !byteReady && count == '0 && state == IDLE) || (underrun && !clearFlags);
      if (state == FETCH) descramblerIn <= rd_q;
      if (state == LATCH) hold <= descramblerOut;
    end
  end
endmodule

// File: tb/tb_mp3_byte_fifo.sv
// tb_mp3_byte_fifo: directed checks of the byte FIFO, big-endian and little-endian instances side by side.
module tb_mp3_byte_fifo;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0, wrEn = 1'b0, clearFlags = 1'b0, byteAck = 1'b0, consumerReq = 1'b0;
  logic [15:0] wrData = '0;
  logic full, overflow, underrun, descramblerAck, byteReady;
  logic full2, overflow2, underrun2, descramblerAck2, byteReady2;
  logic [4:0] wordCount, wordCount2;
  logic [15:0] descramblerIn, descramblerIn2;
  logic [7:0] byteOut, byteOut2;
  int total = 0, bad = 0, ack_cnt = 0, base;
  logic [7:0] got [$];
  logic [7:0] exp_bytes [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

  mp3_byte_fifo #(.DEPTH(16), .LITTLE_ENDIAN(1'b0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wrData(wrData), .wrEn(wrEn), .full(full),
    .wordCount(wordCount), .overflow(overflow), .underrun(underrun), .clearFlags(clearFlags),
    .descramblerIn(descramblerIn), .descramblerOut(descramblerIn), .descramblerAck(descramblerAck),
    .byteOut(byteOut), .byteReady(byteReady), .byteAck(byteAck), .consumerReq(consumerReq));

  mp3_byte_fifo #(.DEPTH(16), .LITTLE_ENDIAN(1'b1)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .wrData(wrData), .wrEn(wrEn), .full(full2),
    .wordCount(wordCount2), .overflow(overflow2), .underrun(underrun2), .clearFlags(clearFlags),
    .descramblerIn(descramblerIn2), .descramblerOut(descramblerIn2), .descramblerAck(descramblerAck2),
    .byteOut(byteOut2), .byteReady(byteReady2), .byteAck(byteAck), .consumerReq(consumerReq));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && descramblerAck) ack_cnt <= ack_cnt + 1;
    if (reset && byteReady && byteAck) got.push_back(byteOut);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(2);
    chk("rst_full", full, 0);
    chk("rst_count", wordCount, 0);
    chk("rst_ready", byteReady, 0);
    chk("rst_byte", byteOut, 0);
    chk("rst_ack", descramblerAck, 0);
    chk("rst_din", descramblerIn, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unr", underrun, 0);
    reset = 1'b1;
    step();
    // single word A55A, bypass descrambler
    wrData = 16'hA55A; wrEn = 1'b1;
    step();
    wrEn = 1'b0;
    chk("t1_count1", wordCount, 1);
    step();
    chk("t1_fetch_ready", byteReady, 0);
    step();
    chk("t1_latch_ack", descramblerAck, 1);
    chk("t1_latch_ready", byteReady, 0);
    step();
    chk("t1_ready", byteReady, 1);
    chk("t1_byte0", byteOut, 8'hA5);
    byteAck = 1'b1;
    step();
    chk("t1_byte1", byteOut, 8'h5A);
    chk("t1_ready1", byteReady, 1);
    step();
    byteAck = 1'b0;
    chk("t1_idle", byteReady, 0);
    chk("t1_acks", ack_cnt, 1);
    chk("t1_din", descramblerIn, 16'hA55A);
    // three words streamed with immediate acks
    got.delete();
    base = ack_cnt;
    wrEn = 1'b1;
    wrData = 16'h0102; step();
    wrData = 16'h0304; step();
    wrData = 16'h0506; step();
    wrEn = 1'b0;
    for (int i = 0; i < 30; i++) begin
      byteAck = byteReady;
      step();
    end
    byteAck = 1'b0;
    chk("t2_nbytes", got.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_byte%0d", i), i < got.size() ? got[i] : 8'hxx, exp_bytes[i]);
    chk("t2_acks", ack_cnt - base, 3);
    chk("t2_count", wordCount, 0);
    chk("t2_unr", underrun, 0);
    // fill to full, then overflow
    wrEn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wrData = 16'h0100 + 16'(i);
      step();
    end
    chk("t3_count15", wordCount, 15);
    chk("t3_notfull", full, 0);
    wrData = 16'hEEEE; step();
    chk("t3_full", full, 1);
    chk("t3_count16", wordCount, 16);
    chk("t3_noovf", overflow, 0);
    wrData = 16'hDDDD; step();
    wrEn = 1'b0;
    chk("t3_ovf", overflow, 1);
    chk("t3_count_hold", wordCount, 16);
    chk("t3_byte0", byteOut, 8'h01);
    byteAck = 1'b1; step(); byteAck = 1'b0;
    chk("t3_byte1", byteOut, 8'h00);
    // flush while in BYTE1 with words queued
    base = ack_cnt;
    flush = 1'b1; step(); flush = 1'b0;
    chk("t5_ready", byteReady, 0);
    chk("t5_count", wordCount, 0);
    chk("t5_full", full, 0);
    chk("t5_ovf", overflow, 0);
    step(6);
    chk("t5_noack", ack_cnt - base, 0);
    chk("t5_still_idle", byteReady, 0);
    // flush during LATCH suppresses the key step
    wrData = 16'hBEEF; wrEn = 1'b1; step(); wrEn = 1'b0;
    step(2);
    chk("tl_latch", descramblerAck, 1);
    base = ack_cnt;
    flush = 1'b1; #1;
    chk("tl_suppr", descramblerAck, 0);
    step(); flush = 1'b0;
    step(4);
    chk("tl_noack", ack_cnt - base, 0);
    chk("tl_noready", byteReady, 0);
    // underrun set, clear, set-wins, no set during refill
    consumerReq = 1'b1; step();
    chk("t4_unr", underrun, 1);
    consumerReq = 1'b0; clearFlags = 1'b1; step();
    chk("t4_clr", underrun, 0);
    consumerReq = 1'b1; step();
    chk("t4_setwins", underrun, 1);
    consumerReq = 1'b0; step(); clearFlags = 1'b0;
    chk("t4_clr2", underrun, 0);
    wrData = 16'hC33C; wrEn = 1'b1; step(); wrEn = 1'b0;
    consumerReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4_refill%0d", i), underrun, 0);
    end
    chk("t4_ready", byteReady, 1);
    chk("t4_byte0", byteOut, 8'hC3);
    consumerReq = 1'b0;
    byteAck = 1'b1; step(2); byteAck = 1'b0;
    // little-endian instance and async reset
    reset = 1'b0; step(); reset = 1'b1;
    chk("t6_rst_count", wordCount2, 0);
    wrData = 16'h1234; wrEn = 1'b1; step(); wrEn = 1'b0;
    step(3);
    chk("t6_le_b0", byteOut2, 8'h34);
    chk("t6_be_b0", byteOut, 8'h12);
    byteAck = 1'b1; step();
    chk("t6_le_b1", byteOut2, 8'h12);
    chk("t6_be_b1", byteOut, 8'h34);
    step(); byteAck = 1'b0;
    chk("t6_le_idle", byteReady2, 0);
    wrEn = 1'b1; step(); wrEn = 1'b0;
    step(3);
    chk("t6_le_ready", byteReady2, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_ready2", byteReady2, 0);
    chk("t6_async_ready", byteReady, 0);
    chk("t6_async_byte", byteOut2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
